// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard scoreboard: stage register numbers and
// write flags in, stall/flush and bypass/forward selects out.
interface hazard_scoreboard_if #(
  parameter int AW    = 5,
  parameter int LAT_W = 4
);
  logic [AW-1:0]    id_rs;
  logic [AW-1:0]    id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_reg_write;
  logic [AW-1:0]    id_num_write;
  logic             id_is_long;
  logic [LAT_W-1:0] id_long_lat;
  logic             exe_reg_write;
  logic             exe_is_load;
  logic [AW-1:0]    exe_num_write;
  logic             mem_reg_write;
  logic [AW-1:0]    mem_num_write;
  logic             wb_reg_write;
  logic [AW-1:0]    wb_num_write;

  logic             stall;
  logic             flush;
  logic [1:0]       id_byp_a;
  logic [1:0]       id_byp_b;
  logic [1:0]       exe_fwd_a;
  logic [1:0]       exe_fwd_b;
  logic             long_busy;
  logic             long_wb_valid;
  logic [AW-1:0]    long_num_write;
  logic [1:0]       long_state;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write, id_num_write,
           id_is_long, id_long_lat, exe_reg_write, exe_is_load, exe_num_write,
           mem_reg_write, mem_num_write, wb_reg_write, wb_num_write,
    input  stall, flush, id_byp_a, id_byp_b, exe_fwd_a, exe_fwd_b,
           long_busy, long_wb_valid, long_num_write, long_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write, id_num_write,
           id_is_long, id_long_lat, exe_reg_write, exe_is_load, exe_num_write,
           mem_reg_write, mem_num_write, wb_reg_write, wb_num_write,
    output stall, flush, id_byp_a, id_byp_b, exe_fwd_a, exe_fwd_b,
           long_busy, long_wb_valid, long_num_write, long_state
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Unified load-use / long-unit hazard detection, ID bypass and registered EXE
// forwarding for the 5-stage pipeline. HAZ_PERF_CNT_EN adds stall counters.
module hazard_scoreboard #(
  parameter int AW    = 5,
  parameter int LAT_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  hazard_scoreboard_if.slave   bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          long_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_BUSY = 2'd1,
    L_DONE = 2'd2
  } long_state_t;

  long_state_t      state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    dest_q, dest_d;
  logic [1:0]       fwd_a_q, fwd_b_q;

  logic             load_use, long_raw, long_waw, long_struct, long_active;
  logic             stall, issue;
  logic [LAT_W-1:0] lat_eff;
  logic [1:0]       fwd_a_d, fwd_b_d, byp_a, byp_b;

  // Register 0 is hardwired, so it never produces a hazard.
  function automatic logic hit(input logic uses, input logic [AW-1:0] src,
                               input logic [AW-1:0] dst);
    return uses && (src == dst) && (dst != '0);
  endfunction

  // Handshake: stall=1 means the ID instruction is not accepted this cycle;
  // PC and IF/ID hold and ID/EXE receives a bubble (flush mirrors stall).
  always_comb begin
    long_active = (state_q == L_BUSY);
    load_use    = bus.exe_reg_write && bus.exe_is_load &&
                  (hit(bus.id_uses_rs, bus.id_rs, bus.exe_num_write) ||
                   hit(bus.id_uses_rt, bus.id_rt, bus.exe_num_write));
    long_raw    = long_active &&
                  (hit(bus.id_uses_rs, bus.id_rs, dest_q) ||
                   hit(bus.id_uses_rt, bus.id_rt, dest_q));
    long_waw    = long_active && hit(bus.id_reg_write, bus.id_num_write, dest_q);
    long_struct = long_active && bus.id_is_long;
    stall       = load_use || long_raw || long_waw || long_struct;
    issue       = bus.id_is_long && !stall;
    lat_eff     = (bus.id_long_lat == '0) ? LAT_W'(1) : bus.id_long_lat;
  end

  // The issue edge itself counts as the first latency cycle, so BUSY lasts
  // L-1 cycles and the DONE cycle lands exactly L cycles after issue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    case (state_q)
      L_IDLE, L_DONE: begin
        if (issue) begin
          dest_d = bus.id_num_write;
          if (lat_eff == LAT_W'(1)) begin
            state_d = L_DONE;
            cnt_d   = '0;
          end else begin
            state_d = L_BUSY;
            cnt_d   = lat_eff - LAT_W'(1);
          end
        end else begin
          state_d = L_IDLE;
          cnt_d   = '0;
        end
      end
      L_BUSY: begin
        if (cnt_q == LAT_W'(1)) begin
          state_d = L_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      default: begin
        state_d = L_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= L_IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
    end
  end

  // EXE producer is younger than MEM producer, so it is checked first.
  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (hit(bus.id_uses_rs, bus.id_rs, bus.exe_num_write) && bus.exe_reg_write)
      fwd_a_d = 2'b01;
    else if (hit(bus.id_uses_rs, bus.id_rs, bus.mem_num_write) && bus.mem_reg_write)
      fwd_a_d = 2'b10;
    if (hit(bus.id_uses_rt, bus.id_rt, bus.exe_num_write) && bus.exe_reg_write)
      fwd_b_d = 2'b01;
    else if (hit(bus.id_uses_rt, bus.id_rt, bus.mem_num_write) && bus.mem_reg_write)
      fwd_b_d = 2'b10;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (stall) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  always_comb begin
    byp_a = 2'b00;
    byp_b = 2'b00;
    if ((state_q == L_DONE) && hit(bus.id_uses_rs, bus.id_rs, dest_q))
      byp_a = 2'b10;
    else if (bus.wb_reg_write && hit(bus.id_uses_rs, bus.id_rs, bus.wb_num_write))
      byp_a = 2'b01;
    if ((state_q == L_DONE) && hit(bus.id_uses_rt, bus.id_rt, dest_q))
      byp_b = 2'b10;
    else if (bus.wb_reg_write && hit(bus.id_uses_rt, bus.id_rt, bus.wb_num_write))
      byp_b = 2'b01;
  end

  assign bus.stall          = stall;
  assign bus.flush          = stall;
  assign bus.id_byp_a       = byp_a;
  assign bus.id_byp_b       = byp_b;
  assign bus.exe_fwd_a      = fwd_a_q;
  assign bus.exe_fwd_b      = fwd_b_q;
  assign bus.long_busy      = (state_q != L_IDLE);
  assign bus.long_wb_valid  = (state_q == L_DONE);
  assign bus.long_num_write = dest_q;
  assign bus.long_state     = state_q;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt      <= '0;
      long_stall_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (stall && !load_use && (long_stall_cnt != '1))
        long_stall_cnt <= long_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
